// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan decoder and its glyph lookup.
package seg_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned NUM_GLYPHS = 16;
  localparam int unsigned CNT_W      = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Glyph for hex value i lives at bits [i*SEG_W +: SEG_W]; segment order a..g = bit6..bit0.
  localparam logic [NUM_GLYPHS*SEG_W-1:0] GLYPH_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_e;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/seg_glyph_lookup.sv
// Combinational seven-segment pattern to hex nibble lookup, with legal and blank flags.
module seg_glyph_lookup
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic [NIB_W-1:0] nibble_c,
  output logic             legal_c,
  output logic             blank_c
);

  always_comb begin
    nibble_c = '0;
    legal_c  = 1'b0;
    blank_c  = (seg_i == SEG_BLANK);
    for (int i = 0; i < NUM_GLYPHS; i++) begin
      if (seg_i == GLYPH_TABLE[i*SEG_W +: SEG_W]) begin
        nibble_c = NIB_W'(i);
        legal_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed seven-segment scan: settle-filter each
// digit strobe, capture once per stable period, and flag completed frames.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_DIGITS    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SEG_W-1:0]            seg_i,
  input  logic [NUM_DIGITS-1:0]       an_i,
  output logic [NIB_W*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]       valid_o,
  output logic [NUM_DIGITS-1:0]       blank_o,
  output logic [NUM_DIGITS-1:0]       err_o,
  output logic                        frame_done_o
);

  localparam int unsigned SAMPLE_W   = NUM_DIGITS + SEG_W;
  localparam cnt_t        SETTLE_CNT = cnt_t'(SETTLE_CYCLES);

  state_e                      state_q, state_d;
  cnt_t                        cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]         sample_q, sample_d;
  logic [NIB_W*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]       valid_q, valid_d;
  logic [NUM_DIGITS-1:0]       blank_q, blank_d;
  logic [NUM_DIGITS-1:0]       err_q, err_d;
  logic [NUM_DIGITS-1:0]       mask_q, mask_d;
  logic                        frame_done_q, frame_done_d;

  logic [SAMPLE_W-1:0]         sample_c;
  logic                        onehot_c;
  logic                        changed_c;
  logic                        capture_c;
  logic [NUM_DIGITS-1:0]       mask_acc_c;

  logic [NIB_W-1:0]            nibble_c;
  logic                        legal_c;
  logic                        blank_c;

  seg_glyph_lookup u_lookup (
    .seg_i    (seg_i),
    .nibble_c (nibble_c),
    .legal_c  (legal_c),
    .blank_c  (blank_c)
  );

  assign sample_c  = {an_i, seg_i};
  assign onehot_c  = $onehot(an_i);
  assign changed_c = (sample_c != sample_q);

  // Settle FSM: the capture fires only on the SETTLE->HELD edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    if (!onehot_c) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE || changed_c) begin
      cnt_d = cnt_t'(1);
      if (cnt_d == SETTLE_CNT) begin
        capture_c = 1'b1;
        state_d   = ST_HELD;
      end else begin
        state_d = ST_SETTLE;
      end
    end else if (state_q == ST_SETTLE) begin
      if (cnt_q < SETTLE_CNT) begin
        cnt_d = cnt_q + cnt_t'(1);
      end
      if (cnt_d == SETTLE_CNT) begin
        capture_c = 1'b1;
        state_d   = ST_HELD;
      end
    end
  end

  // Capture datapath and frame tracking.
  always_comb begin
    sample_d     = sample_c;
    digits_d     = digits_q;
    valid_d      = valid_q;
    blank_d      = blank_q;
    err_d        = err_q;
    mask_d       = mask_q;
    mask_acc_c   = mask_q;
    frame_done_d = 1'b0;
    if (capture_c) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (an_i[k]) begin
          valid_d[k] = legal_c;
          blank_d[k] = blank_c;
          err_d[k]   = !legal_c && !blank_c;
          if (legal_c) begin
            digits_d[k*NIB_W +: NIB_W] = nibble_c;
          end
        end
      end
      mask_acc_c = mask_q | an_i;
      if (&mask_acc_c) begin
        frame_done_d = 1'b1;
        mask_d       = '0;
      end else begin
        mask_d = mask_acc_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sample_q     <= '0;
      digits_q     <= '0;
      valid_q      <= '0;
      blank_q      <= '0;
      err_q        <= '0;
      mask_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sample_q     <= sample_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      blank_q      <= blank_d;
      err_q        <= err_d;
      mask_q       <= mask_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digits_o     = digits_q;
  assign valid_o      = valid_q;
  assign blank_o      = blank_q;
  assign err_o        = err_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed vector table, hand sequences,
// and randomized scans compared each cycle against a run-length reference model.
module tb_seg_scan_decoder;

  localparam int N = 4;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  seg_i = '0;
  logic [3:0]  an_i = '0;
  logic [15:0] digits_o;
  logic [3:0]  valid_o, blank_o, err_o;
  logic        frame_done_o;

  seg_scan_decoder #(.SETTLE_CYCLES(S), .NUM_DIGITS(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_i        (seg_i),
    .an_i         (an_i),
    .digits_o     (digits_o),
    .valid_o      (valid_o),
    .blank_o      (blank_o),
    .err_o        (err_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fd_count = 0;

  logic [6:0] glyphs [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model: a capture happens when a one-hot sample has been seen exactly S times in a row.
  int          run;
  logic [10:0] last;
  bit          have_last;
  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_blank, m_err, m_mask;
  logic        m_fd;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          cycles;
    logic [15:0] dig;
    logic [3:0]  val;
    logic [3:0]  blk;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs[$];

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (glyphs[i] == s) return i;
    return -1;
  endfunction

  function automatic int popcount(input logic [3:0] a);
    int c = 0;
    for (int i = 0; i < 4; i++) if (a[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    run = 0; have_last = 0; last = '0;
    m_digits = '0; m_valid = '0; m_blank = '0; m_err = '0; m_mask = '0; m_fd = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] an, input logic [6:0] seg);
    logic [10:0] smp;
    int d;
    int k;
    smp = {an, seg};
    if (have_last && smp == last) run++;
    else run = 1;
    last = smp;
    have_last = 1;
    m_fd = 1'b0;
    if (popcount(an) == 1 && run == S) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (an[i]) k = i;
      d = decode(seg);
      if (d >= 0) begin
        m_digits[k*4 +: 4] = d[3:0];
        m_valid[k] = 1'b1; m_blank[k] = 1'b0; m_err[k] = 1'b0;
      end else if (seg == 7'h00) begin
        m_valid[k] = 1'b0; m_blank[k] = 1'b1; m_err[k] = 1'b0;
      end else begin
        m_valid[k] = 1'b0; m_blank[k] = 1'b0; m_err[k] = 1'b1;
      end
      m_mask[k] = 1'b1;
      if (m_mask == 4'hF) begin
        m_fd = 1'b1;
        m_mask = '0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".digits"},     32'(digits_o),     32'(m_digits));
    check({tag, ".valid"},      32'(valid_o),      32'(m_valid));
    check({tag, ".blank"},      32'(blank_o),      32'(m_blank));
    check({tag, ".err"},        32'(err_o),        32'(m_err));
    check({tag, ".frame_done"}, 32'(frame_done_o), 32'(m_fd));
  endtask

  // Called at a negedge: drive, let one rising edge happen, compare at the next negedge.
  task automatic cycle(input logic [3:0] an, input logic [6:0] seg);
    an_i = an;
    seg_i = seg;
    @(posedge clk);
    model_step(an, seg);
    @(negedge clk);
    check_all("cyc");
    if (frame_done_o) fd_count++;
  endtask

  // Reset pulse between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    m_fd = 1'b0;
    check_all("reset");
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add_vec(input logic [3:0] an, input logic [6:0] seg, input int cyc,
                         input logic [15:0] dig, input logic [3:0] val,
                         input logic [3:0] blk, input logic [3:0] err);
    vec_t v;
    v.an = an; v.seg = seg; v.cycles = cyc;
    v.dig = dig; v.val = val; v.blk = blk; v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] an;
    logic [6:0] seg;
    int r;
    int hold;
    logic [3:0] multi [7] = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'hF};

    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed table: settle latency, restart on change, error, blank, multi-hot ignore.
    add_vec(4'b0001, 7'h6D, 3,  16'h0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec(4'b0001, 7'h6D, 1,  16'h0002, 4'b0001, 4'b0000, 4'b0000);
    add_vec(4'b0000, 7'h00, 2,  16'h0002, 4'b0001, 4'b0000, 4'b0000);
    add_vec(4'b0010, 7'h79, 3,  16'h0002, 4'b0001, 4'b0000, 4'b0000);
    add_vec(4'b0010, 7'h33, 4,  16'h0042, 4'b0011, 4'b0000, 4'b0000);
    add_vec(4'b0100, 7'h01, 4,  16'h0042, 4'b0011, 4'b0000, 4'b0100);
    add_vec(4'b1000, 7'h00, 5,  16'h0042, 4'b0011, 4'b1000, 4'b0100);
    add_vec(4'b0011, 7'h6D, 10, 16'h0042, 4'b0011, 4'b1000, 4'b0100);
    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].cycles) cycle(vecs[i].an, vecs[i].seg);
      check($sformatf("vec%0d.digits", i), 32'(digits_o), 32'(vecs[i].dig));
      check($sformatf("vec%0d.valid", i),  32'(valid_o),  32'(vecs[i].val));
      check($sformatf("vec%0d.blank", i),  32'(blank_o),  32'(vecs[i].blk));
      check($sformatf("vec%0d.err", i),    32'(err_o),    32'(vecs[i].err));
    end

    // Full scan with anode gaps: one frame pulse and 16'hFE10.
    do_reset();
    fd_count = 0;
    repeat (5) cycle(4'b0001, 7'h7E);
    repeat (2) cycle(4'b0000, 7'h00);
    repeat (5) cycle(4'b0010, 7'h30);
    repeat (2) cycle(4'b0000, 7'h00);
    repeat (5) cycle(4'b0100, 7'h4F);
    repeat (2) cycle(4'b0000, 7'h00);
    repeat (5) cycle(4'b1000, 7'h47);
    repeat (2) cycle(4'b0000, 7'h00);
    check("scan.digits", 32'(digits_o), 32'h0000_FE10);
    check("scan.valid",  32'(valid_o),  32'h0000_000F);
    check("scan.frames", 32'(fd_count), 32'd1);

    // Reset in mid-settle discards the partial run.
    do_reset();
    repeat (4) cycle(4'b0001, 7'h30);
    check("rst.pre_digits", 32'(digits_o), 32'h1);
    repeat (2) cycle(4'b0001, 7'h7F);
    do_reset();
    check("rst.digits0", 32'(digits_o), 32'h0);
    check("rst.valid0",  32'(valid_o),  32'h0);
    repeat (3) cycle(4'b0001, 7'h7F);
    check("rst.no_early", 32'(valid_o), 32'h0);
    cycle(4'b0001, 7'h7F);
    check("rst.digits8", 32'(digits_o), 32'h8);
    check("rst.valid8",  32'(valid_o),  32'h1);

    // Randomized scans against the model.
    for (int seg_n = 0; seg_n < 400; seg_n++) begin
      r = $urandom_range(0, 9);
      if (r <= 6) an = 4'(1 << $urandom_range(0, 3));
      else if (r == 7) an = 4'h0;
      else an = multi[$urandom_range(0, 6)];
      r = $urandom_range(0, 9);
      if (r <= 6) seg = glyphs[$urandom_range(0, 15)];
      else if (r == 7) seg = 7'h00;
      else seg = 7'($urandom);
      hold = $urandom_range(1, 7);
      if ($urandom_range(0, 49) == 0) do_reset();
      repeat (hold) cycle(an, seg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, which sets the consecutive identical samples required before capture (legal range 1..15).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, which sets the number of multiplexed digit positions.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port seg_i  input  7  segment lines, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-006 SHALL have port an_i  input  NUM_DIGITS  digit strobes, active-high, one-hot when a digit is driven.
REQ-007 SHALL have port digits_o  output  4*NUM_DIGITS  recovered hex values; nibble k corresponds to an_i[k].
REQ-008 SHALL have port valid_o  output  NUM_DIGITS  nibble k holds a legal captured glyph.
REQ-009 SHALL have port blank_o  output  NUM_DIGITS  last capture for digit k was all-off (7'h00).
REQ-010 SHALL have port err_o  output  NUM_DIGITS  last capture for digit k was an illegal pattern.
REQ-011 SHALL have port frame_done_o  output  1  one-cycle pulse when every digit has been captured since the previous pulse.

Function
REQ-012 SHALL decode the glyph table 0..F = 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47 (hex, seg_i order) to nibbles 0..F.
REQ-013 SHALL sample seg_i/an_i on every rising edge; inputs are synchronous to clk, so no synchroniser is used.
REQ-014 SHALL implement FSM IDLE/SETTLE/HELD with the following transitions.
- IDLE: an_i not one-hot (zero or multiple bits set).
- IDLE->SETTLE: one-hot an_i sampled; stable count=1.
- SETTLE: count increments while {an_i,seg_i} equals the previous sample.
- SETTLE->HELD: the capture occurs on the edge where count reaches SETTLE_CYCLES.
- HELD: remains while inputs are unchanged; no further captures.
- Any state: a change of an_i or seg_i restarts to SETTLE (count=1) if an_i is one-hot, else goes to IDLE.
REQ-015 SHALL make captured data visible immediately after the capturing edge, so latency = SETTLE_CYCLES edges from the first stable sample.
REQ-016 SHALL apply the following on capture of a legal glyph: nibble k=value, valid_o[k]=1, blank_o[k]=0, err_o[k]=0.
REQ-017 SHALL apply the following on capture of 7'h00: nibble k unchanged, valid_o[k]=0, blank_o[k]=1, err_o[k]=0.
REQ-018 SHALL apply the following on capture of any other pattern: nibble k unchanged, valid_o[k]=0, blank_o[k]=0, err_o[k]=1.
REQ-019 SHALL keep a captured-mask: bit k is set on any capture (legal, blank or error) for digit k.
REQ-020 SHALL behave as follows when the mask becomes all-ones: frame_done_o=1 for exactly one cycle, and the mask clears on that same edge.
REQ-021 SHALL preserve, when a digit is re-captured before the frame completes, the mask bit and the frame_done timing, and SHALL update that digit's outputs.
REQ-022 SHALL use a stable counter that saturates at SETTLE_CYCLES and never wraps.
REQ-023 SHALL hold all outputs stable while in IDLE; the anode gap between digits is not an error.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear: state=IDLE, count=0, mask=0, digits_o=0, valid_o=0, blank_o=0, err_o=0, frame_done_o=0.
REQ-025 SHALL, when reset asserts mid-SETTLE, discard the partial settle; after release, a capture requires a fresh SETTLE_CYCLES stable samples.

Structure
REQ-026 SHALL place the glyph constants, the state enum (IDLE/SETTLE/HELD) and the blank pattern in the shared package seg_pkg.
REQ-027 SHALL place the combinational glyph-to-nibble lookup in sub-module seg_glyph_lookup (7-bit in; nibble, legal, blank out), which is reusable by the display encoder side.

Verification
REQ-028 SHALL cover: an_i=0001, seg_i=7'h6D held 4 cycles -> after 4th edge digits_o[3:0]=2, valid_o=0001; after 3 edges no change.
REQ-029 SHALL cover: an_i=0010, seg_i=7'h79 for 3 cycles, then 7'h33 for 4 cycles -> nibble1=4, never 3.
REQ-030 SHALL cover: scan digits 0..3 with glyphs 7E,30,4F,47, 5 cycles each, gaps an_i=0 -> digits_o=16'hFE10, one frame_done_o pulse.
REQ-031 SHALL cover: an_i=0100, seg_i=7'h01 held 4 cycles -> err_o[2]=1, valid_o[2]=0, nibble2 retains its prior value.
REQ-032 SHALL cover: an_i=1000, seg_i=7'h00 held -> blank_o[3]=1; an_i=0011 held 10 cycles -> no capture, state IDLE.
REQ-033 SHALL cover: rst_n pulsed low after 2 stable cycles of 7'h7F -> all outputs 0 immediately; after release 4 more stable cycles -> nibble=8.
